video_timing_detector: RTL and testbench

- Sink-side counterpart of the HDMI timing generator; sits after the TMDS decoder on the pixclk domain.
- Consumes the decoded VDE and sync control bits (CD = {vsync, hsync}).
- Recovers per-pixel x/y coordinates and measures line/frame geometry.
- Asserts a lock flag once the incoming timing is stable, which gates the downstream frame-buffer writer.

---
 rtl/video_timing_detector.sv | 177 +++++++++++++++++
 tb/tb_video_timing_detector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_detector.sv
// video_timing_detector: recovers pixel coordinates, measures incoming line/frame geometry and flags stable timing
module video_timing_detector #(
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 3,
   parameter int TIMEOUT         = 4095
) (
   input  logic        pixclk,
   input  logic        rst,
   input  logic        VDE,
   input  logic [1:0]  CD,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic [10:0] h_total,
   output logic [10:0] h_active,
   output logic [9:0]  v_total,
   output logic [9:0]  v_active,
   output logic        locked,
   output logic        timing_err
);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
   localparam logic [WDW-1:0] WD_FIRE = WDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   logic           r_vde, r_hs, r_vs;
   logic           r_vde_d, r_hs_d, r_vs_d;
   logic [10:0]    r_hcnt, r_acnt, r_pix_x, r_h_total, r_h_active;
   logic [9:0]     r_vcnt, r_lcnt, r_pix_y, r_v_total, r_v_active;
   logic           r_h_seen, r_a_seen, r_v_seen;
   logic [WDW-1:0] r_wd;
   state_t         r_state;
   logic [3:0]     r_match;
   logic [10:0]    r_s_ht, r_s_ha;
   logic [9:0]     r_s_vt, r_s_va;
   logic           r_locked, r_err;

   logic           w_hs_le, w_vs_le, w_vde_fe, w_to, w_match;
   logic [9:0]     w_vcnt_inc, w_lcnt_inc;
   logic [10:0]    w_h_total_n, w_h_active_n;
   logic [9:0]     w_v_total_n, w_v_active_n;

   assign w_hs_le  = r_hs & ~r_hs_d;
   assign w_vs_le  = r_vs & ~r_vs_d;
   assign w_vde_fe = r_vde_d & ~r_vde;
   assign w_to     = ~w_hs_le && (r_wd == WD_FIRE);

   // A coincident hs edge is counted before the vs latch so the latched line count includes it
   assign w_vcnt_inc = (w_hs_le && r_vcnt != 10'h3ff) ? r_vcnt + 10'd1 : r_vcnt;
   assign w_lcnt_inc = (w_vde_fe && r_lcnt != 10'h3ff) ? r_lcnt + 10'd1 : r_lcnt;

   // Measurements are only latched once a complete interval has been seen since reset
   assign w_h_total_n  = (w_hs_le && r_h_seen) ? r_hcnt : r_h_total;
   assign w_h_active_n = (w_vde_fe && r_a_seen) ? r_acnt : r_h_active;
   assign w_v_total_n  = (w_vs_le && r_v_seen) ? w_vcnt_inc : r_v_total;
   assign w_v_active_n = (w_vs_le && r_v_seen) ? w_lcnt_inc : r_v_active;

   assign w_match = (w_h_total_n == r_s_ht) && (w_h_active_n == r_s_ha) &&
                    (w_v_total_n == r_s_vt) && (w_v_active_n == r_s_va);

   assign pix_valid  = r_vde;
   assign pix_x      = r_pix_x;
   assign pix_y      = r_pix_y;
   assign h_total    = r_h_total;
   assign h_active   = r_h_active;
   assign v_total    = r_v_total;
   assign v_active   = r_v_active;
   assign locked     = r_locked;
   assign timing_err = r_err;

   // Register decoded inputs once and keep a delayed copy for edge detection; reset looks like idle
   always_ff @(posedge pixclk) begin
      if (rst) begin
         r_vde   <= 1'b0;
         r_hs    <= 1'b0;
         r_vs    <= 1'b0;
         r_vde_d <= 1'b0;
         r_hs_d  <= 1'b0;
         r_vs_d  <= 1'b0;
      end else begin
         r_vde   <= VDE;
         r_hs    <= CD[0] ^ SYNC_ACTIVE_LOW;
         r_vs    <= CD[1] ^ SYNC_ACTIVE_LOW;
         r_vde_d <= r_vde;
         r_hs_d  <= r_hs;
         r_vs_d  <= r_vs;
      end
   end

   // Horizontal line length, active width and the pixel column aligned with pix_valid
   always_ff @(posedge pixclk) begin
      if (rst) begin
         r_hcnt     <= '0;
         r_acnt     <= '0;
         r_pix_x    <= '0;
         r_h_total  <= '0;
         r_h_active <= '0;
         r_h_seen   <= 1'b0;
         r_a_seen   <= 1'b0;
      end else begin
         r_hcnt     <= w_hs_le ? 11'd1 : (r_hcnt != 11'h7ff) ? r_hcnt + 11'd1 : r_hcnt;
         r_acnt     <= w_vde_fe ? 11'd0 : (r_vde && r_acnt != 11'h7ff) ? r_acnt + 11'd1 : r_acnt;
         r_pix_x    <= !VDE ? r_pix_x : !r_vde ? 11'd0 : (r_pix_x != 11'h7ff) ? r_pix_x + 11'd1 : r_pix_x;
         r_h_total  <= w_h_total_n;
         r_h_active <= w_h_active_n;
         r_h_seen   <= r_h_seen | w_hs_le;
         r_a_seen   <= r_a_seen | w_vde_fe;
      end
   end

   // Vertical frame length, active line count and the pixel row
   always_ff @(posedge pixclk) begin
      if (rst) begin
         r_vcnt     <= '0;
         r_lcnt     <= '0;
         r_pix_y    <= '0;
         r_v_total  <= '0;
         r_v_active <= '0;
         r_v_seen   <= 1'b0;
      end else begin
         r_vcnt     <= w_vs_le ? 10'd0 : w_vcnt_inc;
         r_lcnt     <= w_vs_le ? 10'd0 : w_lcnt_inc;
         r_pix_y    <= w_vs_le ? 10'd0 : (w_vde_fe && r_pix_y != 10'h3ff) ? r_pix_y + 10'd1 : r_pix_y;
         r_v_total  <= w_v_total_n;
         r_v_active <= w_v_active_n;
         r_v_seen   <= r_v_seen | w_vs_le;
      end
   end

   // Watchdog counts cycles since the last hs edge and parks at TIMEOUT so it fires only once
   always_ff @(posedge pixclk) begin
      if (rst)
         r_wd <= '0;
      else
         r_wd <= w_hs_le ? '0 : (r_wd != WD_MAX) ? r_wd + 1'b1 : r_wd;
   end

   // Lock FSM: compares each frame's measurements against a snapshot, evaluated at vs edges
   always_ff @(posedge pixclk) begin
      if (rst) begin
         r_state  <= SEARCH;
         r_match  <= '0;
         r_s_ht   <= '0;
         r_s_ha   <= '0;
         r_s_vt   <= '0;
         r_s_va   <= '0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (w_to) begin
            r_state  <= SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
            r_err    <= (r_state == LOCKED);
         end else if (w_vs_le) begin
            if (r_state == SEARCH || !w_match) begin
               r_state  <= CHECK;
               r_match  <= '0;
               r_s_ht   <= w_h_total_n;
               r_s_ha   <= w_h_active_n;
               r_s_vt   <= w_v_total_n;
               r_s_va   <= w_v_active_n;
               r_locked <= 1'b0;
               r_err    <= (r_state == LOCKED);
            end else if (r_state == CHECK) begin
               r_match <= r_match + 4'd1;
               if (int'(r_match) + 1 >= LOCK_FRAMES - 1) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_video_timing_detector.sv
// tb_video_timing_detector: directed scenarios on a scaled video pattern with a pixel scoreboard
module tb_video_timing_detector;
   localparam int HT  = 100;
   localparam int HA  = 64;
   localparam int HB  = 20;
   localparam int HSW = 12;
   localparam int VT  = 16;
   localparam int VA  = 10;
   localparam int VB  = 4;
   localparam int VSW = 2;
   localparam int TO  = 4095;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   logic        pixclk = 1'b0;
   logic        rst = 1'b1;
   logic        vde = 1'b0;
   logic        hs_i = 1'b0;
   logic        vs_i = 1'b0;
   logic [1:0]  cd1, cd2;
   logic        pv1, pv2, lk1, lk2, te1, te2;
   logic [10:0] px1, px2, ht1, ht2, ha1, ha2;
   logic [9:0]  py1, py2, vt1, vt2, va1, va2;

   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   err_cnt = 0;
   int   err2_cnt = 0;
   int   err_cyc = 0;
   int   last_hs_cyc = 0;
   int   m_y = 0;
   pix_t sq[$];
   pix_t e_pix;

   assign cd1 = {~vs_i, ~hs_i};
   assign cd2 = {vs_i, hs_i};

   video_timing_detector #(.SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(3), .TIMEOUT(TO)) dut (
      .pixclk(pixclk), .rst(rst), .VDE(vde), .CD(cd1),
      .pix_valid(pv1), .pix_x(px1), .pix_y(py1),
      .h_total(ht1), .h_active(ha1), .v_total(vt1), .v_active(va1),
      .locked(lk1), .timing_err(te1)
   );

   video_timing_detector #(.SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(3), .TIMEOUT(TO)) dut_inv (
      .pixclk(pixclk), .rst(rst), .VDE(vde), .CD(cd2),
      .pix_valid(pv2), .pix_x(px2), .pix_y(py2),
      .h_total(ht2), .h_active(ha2), .v_total(vt2), .v_active(va2),
      .locked(lk2), .timing_err(te2)
   );

   always #5 pixclk = ~pixclk;

   always @(posedge pixclk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge pixclk) begin
      if (te1) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (te2) err2_cnt++;
      if (pv1) begin
         if (sq.size() == 0) chk("pix_valid_spurious", pv1, 0);
         else begin
            e_pix = sq.pop_front();
            chk("pix_latency", cyc, e_pix.c);
            chk("pix_x", px1, e_pix.x);
            chk("pix_y", py1, e_pix.y);
         end
      end else if (sq.size() != 0 && sq[0].c <= cyc) begin
         chk("pix_valid_missing", pv1, 1);
         void'(sq.pop_front());
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_pix_valid"}, pv1, 0);
      chk({tag, "_pix_x"}, px1, 0);
      chk({tag, "_pix_y"}, py1, 0);
      chk({tag, "_h_total"}, ht1, 0);
      chk({tag, "_h_active"}, ha1, 0);
      chk({tag, "_v_total"}, vt1, 0);
      chk({tag, "_v_active"}, va1, 0);
      chk({tag, "_locked"}, lk1, 0);
      chk({tag, "_timing_err"}, te1, 0);
      chk({tag, "_inv_h_total"}, ht2, 0);
      chk({tag, "_inv_v_total"}, vt2, 0);
      chk({tag, "_inv_locked"}, lk2, 0);
   endtask

   task automatic cycle(input bit v, input bit h, input bit vs, input int x);
      pix_t p;
      vde  = v;
      hs_i = h;
      vs_i = vs;
      if (v) begin
         p.x = x;
         p.y = m_y;
         p.c = cyc + 1;
         sq.push_back(p);
      end
      @(negedge pixclk);
   endtask

   task automatic line(input int l, input int wlen, input int rst_at);
      bit act_line;
      act_line = (l >= VB) && (l < VB + VA);
      for (int c = 0; c < HT; c++) begin
         if (l == 0 && c == 0) m_y = 0;
         if (act_line && c == HB + wlen) m_y++;
         if (c == 0) last_hs_cyc = cyc;
         if (c == rst_at) rst = 1'b1;
         cycle(act_line && c >= HB && c < HB + wlen, c < HSW, l < VSW, c - HB);
         if (c == rst_at) begin
            rst = 1'b0;
            m_y = 0;
            chk_zero("midframe_reset");
         end
      end
   endtask

   task automatic frame(input int nl, input int sl, input int rl, input bit el, input int ee,
                        input bit cm, input int eha);
      int e1 = err_cnt;
      int e2 = err2_cnt;
      for (int l = 0; l < nl; l++) begin
         line(l, (l == sl) ? HA - 1 : HA, (l == rl) ? 92 : -1);
         if (l == 0) begin
            chk("locked", lk1, el);
            chk("inv_locked", lk2, el);
            chk("timing_err_pulses", err_cnt - e1, ee);
            chk("inv_timing_err_pulses", err2_cnt - e2, ee);
            if (cm) begin
               chk("h_total", ht1, HT);
               chk("h_active", ha1, eha);
               chk("v_total", vt1, VT);
               chk("v_active", va1, VA);
               chk("inv_h_total", ht2, HT);
               chk("inv_h_active", ha2, eha);
               chk("inv_v_total", vt2, VT);
               chk("inv_v_active", va2, VA);
            end
         end
      end
   endtask

   initial begin
      int e1, e2;
      repeat (3) @(negedge pixclk);
      chk_zero("reset");
      rst = 1'b0;
      frame(VT, -1, -1, 0, 0, 0, HA);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 1, 0, 1, HA);
      frame(VT, VB + VA - 1, -1, 1, 0, 1, HA);
      frame(VT, -1, -1, 0, 1, 1, HA - 1);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 1, 0, 1, HA);
      frame(VB + 1, -1, -1, 1, 0, 1, HA);
      e1 = err_cnt;
      e2 = err2_cnt;
      repeat (5000) cycle(0, 0, 0, 0);
      chk("timeout_pulses", err_cnt - e1, 1);
      chk("inv_timeout_pulses", err2_cnt - e2, 1);
      chk("timeout_pulse_cycle", err_cyc, last_hs_cyc + TO + 2);
      chk("timeout_locked", lk1, 0);
      chk("inv_timeout_locked", lk2, 0);
      frame(VT, -1, 8, 0, 0, 0, HA);
      frame(VT, -1, -1, 0, 0, 0, HA);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 0, 0, 1, HA);
      frame(VT, -1, -1, 1, 0, 1, HA);
      repeat (4) cycle(0, 0, 0, 0);
      chk("pix_queue_drained", sq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
